// File: rtl/song_recorder.sv
// ---------------------------------------------------------------------------
// song_recorder
//
// Writer side of the song map. Captures a melody played on the keypad,
// quantized to the game beat, and writes it into song memory as
// (note, hold_length) entries. Also reports the take length, which the
// frame counter uses as its stop value.
//
// Build option:
//   SKIP_LEAD_REST_EN - when defined, ARM waits for the first beat with a
//                       pressed key, so a take never starts with a rest.
//
// Ports:
//   CLOCK_50   in   system clock, every flop is in this domain
//   reset_n    in   asynchronous active-low reset
//   beat       in   game beat level, asynchronous, synchronized here
//   rec_start  in   one-cycle pulse, begin a take (IDLE/DONE only)
//   rec_stop   in   one-cycle pulse, end a take
//   keys       in   one-hot pressed key, 0 = none
//   wr_en      out  one-cycle song memory write strobe
//   wr_addr    out  write address (held after the strobe)
//   wr_note    out  note of the entry, 0 = rest (held after the strobe)
//   wr_hold    out  beats held, 1..MAX_HOLD (held after the strobe)
//   song_len   out  entries written in the last/current take, 0..64
//   recording  out  high while in ARM or REC
//   overflow   out  sticky, take truncated because memory filled
//   state_dbg  out  current FSM state, for debug and checkers
//
// Memory handshake: the memory has no back-pressure. An entry is written on
// every cycle where wr_en=1; wr_addr/wr_note/wr_hold are valid in that cycle.
// ---------------------------------------------------------------------------
module song_recorder #(
    parameter int NOTE_W   = 12,
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 15,
    parameter int ADDR_W   = 6
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              beat,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic [NOTE_W-1:0] keys,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [NOTE_W-1:0] wr_note,
    output logic [HOLD_W-1:0] wr_hold,
    output logic [ADDR_W:0]   song_len,
    output logic              recording,
    output logic              overflow,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_REC   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Number of entries in a full memory.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic              beat_s1_q, beat_s1_d;
    logic              beat_s2_q, beat_s2_d;
    logic              beat_s3_q, beat_s3_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [NOTE_W-1:0] wr_note_q, wr_note_d;
    logic [HOLD_W-1:0] wr_hold_q, wr_hold_d;
    logic [ADDR_W:0]   song_len_q, song_len_d;
    logic              recording_q, recording_d;
    logic              overflow_q, overflow_d;

    logic              beat_tick;
    logic              key_ok;
    logic [NOTE_W-1:0] sample;
    logic              do_emit;

    // beat_s1/s2 form the synchronizer; s3 is the previous synchronized
    // value, so the tick is a single cycle after each rising beat edge.
    assign beat_tick = beat_s2_q & ~beat_s3_q;

    // Zero or exactly one bit set is a legal key; chords record as a rest.
    assign key_ok = ((keys & (keys - NOTE_W'(1))) == '0);
    assign sample = key_ok ? keys : '0;

    always_comb begin
        state_d     = state_q;
        beat_s1_d   = beat;
        beat_s2_d   = beat_s1_q;
        beat_s3_d   = beat_s2_q;
        cur_note_d  = cur_note_q;
        hold_d      = hold_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_note_d   = wr_note_q;
        wr_hold_d   = wr_hold_q;
        song_len_d  = song_len_q;
        overflow_d  = overflow_q;
        do_emit     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (rec_start) begin
                    state_d    = S_ARM;
                    addr_d     = '0;
                    wr_addr_d  = '0;
                    song_len_d = '0;
                    overflow_d = 1'b0;
                end
            end
            S_ARM: begin
                if (rec_stop) begin
                    state_d    = S_DONE;
                    song_len_d = '0;
                end else if (beat_tick) begin
`ifdef SKIP_LEAD_REST_EN
                    if (sample != '0) begin
                        cur_note_d = sample;
                        hold_d     = HOLD_W'(1);
                        state_d    = S_REC;
                    end
`else
                    cur_note_d = sample;
                    hold_d     = HOLD_W'(1);
                    state_d    = S_REC;
`endif
                end
            end
            S_REC: begin
                // Stop has priority over a coincident beat: that beat's
                // sample is discarded and the pre-beat entry is flushed.
                if (rec_stop) begin
                    state_d = S_FLUSH;
                end else if (beat_tick) begin
                    if (sample == cur_note_q && hold_q < HOLD_W'(MAX_HOLD)) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end else begin
                        do_emit    = 1'b1;
                        cur_note_d = sample;
                        hold_d     = HOLD_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                do_emit = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Emission uses the pre-update note/hold; the write fields are
        // registered so they stay valid after the strobe drops.
        if (do_emit) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_q;
            wr_note_d  = cur_note_q;
            wr_hold_d  = hold_q;
            addr_d     = addr_q + ADDR_W'(1);
            song_len_d = song_len_q + (ADDR_W + 1)'(1);
            if (song_len_d == DEPTH) begin
                // Memory full: any partial note in flight is dropped.
                state_d    = S_DONE;
                overflow_d = 1'b1;
            end
        end

        recording_d = (state_d == S_ARM) || (state_d == S_REC);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_s1_q   <= 1'b0;
            beat_s2_q   <= 1'b0;
            beat_s3_q   <= 1'b0;
            cur_note_q  <= '0;
            hold_q      <= '0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_note_q   <= '0;
            wr_hold_q   <= '0;
            song_len_q  <= '0;
            recording_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_s1_q   <= beat_s1_d;
            beat_s2_q   <= beat_s2_d;
            beat_s3_q   <= beat_s3_d;
            cur_note_q  <= cur_note_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_note_q   <= wr_note_d;
            wr_hold_q   <= wr_hold_d;
            song_len_q  <= song_len_d;
            recording_q <= recording_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_note   = wr_note_q;
    assign wr_hold   = wr_hold_q;
    assign song_len  = song_len_q;
    assign recording = recording_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_song_recorder.sv
// ---------------------------------------------------------------------------
// tb_song_recorder
//
// Directed bench for song_recorder. A per-step table (start / beat / stop,
// with the expected write and status) covers the basic takes; hand-written
// sequences cover coincident stop+beat, leading rests, memory overflow and
// reset in the middle of a take. Writes are captured into got_q by a monitor
// and compared against expected entries packed as {addr, note, hold}.
// ---------------------------------------------------------------------------
module tb_song_recorder;

    localparam int K_START = 0;
    localparam int K_BEAT  = 1;
    localparam int K_STOP  = 2;

    logic        CLOCK_50;
    logic        reset_n;
    logic        beat;
    logic        rec_start;
    logic        rec_stop;
    logic [11:0] keys;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [11:0] wr_note;
    logic [3:0]  wr_hold;
    logic [6:0]  song_len;
    logic        recording;
    logic        overflow;
    logic [2:0]  state_dbg;

    song_recorder dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .beat      (beat),
        .rec_start (rec_start),
        .rec_stop  (rec_stop),
        .keys      (keys),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_note   (wr_note),
        .wr_hold   (wr_hold),
        .song_len  (song_len),
        .recording (recording),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // ---------------- scoreboard ----------------
    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always @(negedge CLOCK_50) begin
        if (wr_en) got_q.push_back({wr_addr, wr_note, wr_hold});
    end

    function automatic logic [21:0] ent(input logic [5:0] a, input logic [11:0] n,
                                        input logic [3:0] h);
        return {a, n, h};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_write(input string name, input logic [21:0] exp);
        logic [21:0] got;
        checks++;
        if (got_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no write seen, expected {addr,note,hold}=%h", name, exp);
        end else begin
            got = got_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got {addr,note,hold}=%h expected %h", name, got, exp);
            end
        end
    endtask

    task automatic check_no_write(input string name);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d unexpected writes, first %h expected none",
                     name, got_q.size(), got_q[0]);
            got_q.delete();
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_beat(input logic [11:0] k);
        keys = k;
        beat = 1'b1;
        cyc(6);
        beat = 1'b0;
        cyc(6);
    endtask

    task automatic pulse_start();
        rec_start = 1'b1;
        cyc(1);
        rec_start = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_stop();
        rec_stop = 1'b1;
        cyc(1);
        rec_stop = 1'b0;
        cyc(3);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          kind;
        logic [11:0] keys;
        logic        exp_wr;
        logic [21:0] exp_ent;
        logic [6:0]  exp_len;
        logic        exp_rec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int kind, input logic [11:0] k, input logic wr,
                                input logic [21:0] e, input logic [6:0] len, input logic rec);
        vec_t v;
        v.kind    = kind;
        v.keys    = k;
        v.exp_wr  = wr;
        v.exp_ent = e;
        v.exp_len = len;
        v.exp_rec = rec;
        vecs.push_back(v);
    endfunction

    initial begin
        reset_n   = 1'b0;
        beat      = 1'b0;
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        keys      = '0;

        // Take 1: three beats of one note, a new note, then stop.
        add(K_START, 12'h000, 0, '0,                         7'd0, 1);
        add(K_BEAT,  12'h001, 0, '0,                         7'd0, 1);
        add(K_BEAT,  12'h001, 0, '0,                         7'd0, 1);
        add(K_BEAT,  12'h001, 0, '0,                         7'd0, 1);
        add(K_BEAT,  12'h004, 1, ent(6'd0, 12'h001, 4'd3),   7'd1, 1);
        add(K_STOP,  12'h000, 1, ent(6'd1, 12'h004, 4'd1),   7'd2, 0);
        // Take 2: 17 beats of one note saturate at 15 and split.
        add(K_START, 12'h000, 0, '0,                         7'd0, 1);
        for (int i = 0; i < 15; i++) add(K_BEAT, 12'h800, 0, '0, 7'd0, 1);
        add(K_BEAT,  12'h800, 1, ent(6'd0, 12'h800, 4'd15),  7'd1, 1);
        add(K_BEAT,  12'h800, 0, '0,                         7'd1, 1);
        add(K_STOP,  12'h000, 1, ent(6'd1, 12'h800, 4'd2),   7'd2, 0);
        // Take 3: a chord between two beats of a note records as a rest.
        add(K_START, 12'h000, 0, '0,                         7'd0, 1);
        add(K_BEAT,  12'h010, 0, '0,                         7'd0, 1);
        add(K_BEAT,  12'h003, 1, ent(6'd0, 12'h010, 4'd1),   7'd1, 1);
        add(K_BEAT,  12'h010, 1, ent(6'd1, 12'h000, 4'd1),   7'd2, 1);
        add(K_STOP,  12'h000, 1, ent(6'd2, 12'h010, 4'd1),   7'd3, 0);

        // Reset state.
        cyc(3);
        check("rst_wr_en",   wr_en,     0);
        check("rst_state",   state_dbg, 0);
        reset_n = 1'b1;
        cyc(2);
        check("rst_outputs", {wr_en, wr_addr, wr_note, wr_hold, song_len, recording, overflow}, 0);
        check_no_write("rst_no_write");

        // Table.
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                K_START: pulse_start();
                K_BEAT:  do_beat(vecs[i].keys);
                default: pulse_stop();
            endcase
            if (vecs[i].exp_wr) check_write($sformatf("vec%0d_write", i), vecs[i].exp_ent);
            else                check_no_write($sformatf("vec%0d_nowrite", i));
            check($sformatf("vec%0d_song_len", i),  song_len,  vecs[i].exp_len);
            check($sformatf("vec%0d_recording", i), recording, vecs[i].exp_rec);
        end
        check("take3_overflow", overflow, 0);

        // Stop coincident with a beat tick: the concurrent sample is dropped.
        pulse_start();
        do_beat(12'h020);
        do_beat(12'h020);
        check_no_write("coinc_pre");
        keys = 12'h020;
        beat = 1'b1;
        cyc(2);
        rec_stop = 1'b1;
        cyc(1);
        rec_stop = 1'b0;
        cyc(4);
        beat = 1'b0;
        cyc(6);
        check_write("coinc_flush", ent(6'd0, 12'h020, 4'd2));
        check_no_write("coinc_after");
        check("coinc_song_len", song_len, 1);
        check("coinc_state",    state_dbg, 4);

        // Leading silence.
        pulse_start();
        for (int i = 0; i < 3; i++) do_beat(12'h000);
        check("lead_recording", recording, 1);
        do_beat(12'h040);
`ifdef SKIP_LEAD_REST_EN
        check_no_write("lead_first_note");
        pulse_stop();
        check_write("lead_flush", ent(6'd0, 12'h040, 4'd1));
        check("lead_song_len", song_len, 1);
`else
        check_write("lead_rest", ent(6'd0, 12'h000, 4'd3));
        pulse_stop();
        check_write("lead_flush", ent(6'd1, 12'h040, 4'd1));
        check("lead_song_len", song_len, 2);
`endif

        // Overflow: 70 alternating notes give exactly 64 writes.
        pulse_start();
        for (int i = 0; i < 70; i++) do_beat((i % 2 == 0) ? 12'h001 : 12'h002);
        for (int w = 0; w < 64; w++)
            exp_q.push_back(ent(6'(w), (w % 2 == 0) ? 12'h001 : 12'h002, 4'd1));
        check("ovf_write_count", got_q.size(), 64);
        while (exp_q.size() != 0) check_write("ovf_entry", exp_q.pop_front());
        check("ovf_overflow",  overflow,  1);
        check("ovf_song_len",  song_len,  64);
        check("ovf_recording", recording, 0);
        check("ovf_state",     state_dbg, 4);
        pulse_stop();
        do_beat(12'h004);
        check_no_write("ovf_no_more_writes");

        // Reset in the middle of REC abandons the take.
        pulse_start();
        do_beat(12'h001);
        do_beat(12'h001);
        check("mid_state_rec", state_dbg, 2);
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(6);
        check("mid_outputs", {wr_en, wr_addr, wr_note, wr_hold, song_len, recording, overflow}, 0);
        check("mid_state",   state_dbg, 0);
        check_no_write("mid_no_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Writer side of the song map: captures a player-performed melody from the keypad one-hot bus, quantized to the game beat, as (note, hold_length) entries.
- Entries are written into the song memory that the engine reads back during play.
- Sits between the keypad scanner output and the song memory write port.
- Also reports song length, which feeds the frame counter stop value.

Parameters:
- NOTE_W, 12, width of one-hot note (keys[11:0])
- HOLD_W, 4, width of hold length field
- MAX_HOLD, 15, largest hold stored in one entry
- ADDR_W, 6, song memory address width; depth = 2**ADDR_W = 64 entries

Ports:
- CLOCK_50  input  1  system clock; all logic in this domain
- reset_n  input  1  asynchronous active-low reset
- beat  input  1  game clock level (slow, asynchronous to CLOCK_50)
- rec_start  input  1  single-cycle pulse, begin recording
- rec_stop  input  1  single-cycle pulse, end recording
- keys  input  NOTE_W  one-hot pressed key from keypad scanner, 0 = none
- wr_en  output  1  single-cycle memory write strobe
- wr_addr  output  ADDR_W  write address
- wr_note  output  NOTE_W  note of entry (0 = rest)
- wr_hold  output  HOLD_W  beats held, 1..MAX_HOLD
- song_len  output  ADDR_W+1  entries written in last/current take, 0..64
- recording  output  1  high in ARM and REC
- overflow  output  1  sticky: take truncated because memory filled

Behaviour:
- Reset (async, reset_n=0): state IDLE; wr_en=0, wr_addr=0, wr_note=0, wr_hold=0, song_len=0, recording=0, overflow=0. Memory contents untouched. Reset mid-take abandons the take; no flush write.
- beat passes a 2-FF synchronizer, then a rising-edge detector, giving beat_tick: one CLOCK_50 cycle, 3 cycles after the beat edge.
- Key sample at beat_tick: keys if zero or exactly one bit set; any multi-bit value samples as rest (0).
- States:
  - IDLE: rec_start -> ARM; clear wr_addr, song_len, overflow. rec_stop ignored.
  - ARM: on beat_tick: cur_note = sample, hold = 1 -> REC. rec_stop -> DONE, song_len = 0.
  - REC: on beat_tick:
    - If sample == cur_note and hold < MAX_HOLD: hold += 1.
    - Otherwise emit (cur_note, hold), then cur_note = sample, hold = 1. A hold reaching MAX_HOLD with the same note continuing emits MAX_HOLD, and the next entry restarts at 1.
    - rec_stop -> FLUSH.
  - FLUSH: emit pending (cur_note, hold) -> DONE.
  - DONE: outputs stable; rec_start -> ARM (new take overwrites from address 0).
- Emit:
  - wr_en is high exactly 1 cycle, the cycle after the triggering beat_tick (FLUSH: the cycle after entering FLUSH).
  - wr_note, wr_hold and wr_addr are valid while wr_en=1 and hold their values afterwards.
  - After each write: wr_addr += 1 and song_len += 1.
- Full: when song_len reaches 64 after a write, go to DONE immediately and set overflow. A pending partial note is dropped; no further writes. wr_addr wraps to 0 but is unused.
- Simultaneous rec_stop and beat_tick in REC: stop wins; that beat's sample is discarded and the flush emits the pre-beat entry.
- rec_start while ARM/REC/FLUSH: ignored.
- hold arithmetic is saturating per entry, never wraps.
- Trailing rest at stop is emitted like any note.

Optional Feature:
- Macro: SKIP_LEAD_REST_EN.
- Defined: ARM stays in ARM on beat_tick while the sample is 0. The take starts at the first beat with a nonzero sample, so no leading rest entry is ever written.
- Undefined: ARM leaves on the first beat_tick regardless of sample; leading silence is recorded as rest entries.

Test Plan:
- Start, then over beats keys = 0x001,0x001,0x001,0x004, then stop after the 4th beat -> writes (addr0: 0x001, hold 3) and flush (addr1: 0x004, hold 1); song_len=2, overflow=0.
- 17 consecutive beats of 0x800, then stop -> (0x800, 15) and (0x800, 2); no hold value ever exceeds 15.
- Beat sample keys = 0x003 between 0x010 beats -> recorded as rest: entries (0x010,1), (0x000,1), (0x010,...).
- 70 alternating notes (0x001/0x002) -> exactly 64 writes, addrs 0..63; DONE; overflow=1; song_len=64; no wr_en afterwards.
- rec_stop in the same cycle as beat_tick after (0x020, hold 2) -> flush writes (0x020, 2); the concurrent sample is not counted.
- Assert reset_n=0 mid-REC, then release -> all outputs 0, state IDLE, no write. With SKIP_LEAD_REST_EN: 3 silent beats then 0x040 -> first entry is (0x040, 1) at addr0.
